// File: rtl/panda_pkg.sv
// panda_pkg: shared types and helpers for the panda load-store path.
//   lsu_width_e    - access size encoding carried from the pipeline
//   lsu_state_e    - load-store unit FSM states
//   lsu_misaligned - natural-alignment check for a given access size
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_WIDTH_BYTE   = 2'd0,
        LSU_WIDTH_HALF   = 2'd1,
        LSU_WIDTH_WORD   = 2'd2,
        LSU_WIDTH_DOUBLE = 2'd3
    } lsu_width_e;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_REQ  = 3'd1,
        LSU_WAIT = 3'd2,
        LSU_RESP = 3'd3,
        LSU_ERR  = 3'd4
    } lsu_state_e;

    // An access is misaligned when any address bit below its size is set.
    function automatic logic lsu_misaligned(input lsu_width_e width, input logic [2:0] addr_lsbs);
        logic mis;
        case (width)
            LSU_WIDTH_BYTE:   mis = 1'b0;
            LSU_WIDTH_HALF:   mis = addr_lsbs[0];
            LSU_WIDTH_WORD:   mis = |addr_lsbs[1:0];
            LSU_WIDTH_DOUBLE: mis = |addr_lsbs;
            default:          mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/panda_lsu_if.sv
// panda_lsu_if: request/grant/response data-memory bus.
//   master modport - LSU side: drives req/we/be/addr/wdata, receives gnt/rvalid/rdata/err
//   slave modport  - memory side: the mirror image
interface panda_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NBYTES = XLEN / 8;

    logic              data_req_o;
    logic              data_gnt_i;
    logic              data_we_o;
    logic [NBYTES-1:0] data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [XLEN-1:0]   data_wdata_o;
    logic              data_rvalid_i;
    logic [XLEN-1:0]   data_rdata_i;
    logic              data_err_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
    );
endinterface

// File: rtl/panda_lsu_align.sv
// panda_lsu_align: purely combinational lane steering for the LSU.
//   width_i/unsigned_i/off_i - access size, zero-extend flag, byte offset within the bus word
//   wdata_i -> wdata_o        - right-aligned store data replicated across all lanes
//   be_o                      - byte enables for the access
//   rdata_i -> rdata_o        - bus read data shifted down and sign/zero extended
module panda_lsu_align
    import panda_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_width_e                  width_i,
    input  logic                        unsigned_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic [XLEN-1:0]             wdata_i,
    input  logic [XLEN-1:0]             rdata_i,
    output logic [XLEN/8-1:0]           be_o,
    output logic [XLEN-1:0]             wdata_o,
    output logic [XLEN-1:0]             rdata_o
);
    localparam int NBYTES = XLEN / 8;

    logic [7:0]      mask_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] keep_s;
    logic            sign_s;
    logic            ext_s;

    // Byte enables and replicated store data per access size.
    always_comb begin
        mask_s  = 8'h01;
        wdata_o = wdata_i;
        case (width_i)
            LSU_WIDTH_BYTE: begin
                mask_s  = 8'h01;
                wdata_o = {NBYTES{wdata_i[7:0]}};
            end
            LSU_WIDTH_HALF: begin
                mask_s  = 8'h03;
                wdata_o = {(XLEN/16){wdata_i[15:0]}};
            end
            LSU_WIDTH_WORD: begin
                mask_s  = 8'h0F;
                wdata_o = {(XLEN/32){wdata_i[31:0]}};
            end
            LSU_WIDTH_DOUBLE: begin
                mask_s  = 8'hFF;
                wdata_o = wdata_i;
            end
            default: begin
                mask_s  = 8'h01;
                wdata_o = wdata_i;
            end
        endcase
        // Lanes pushed past the top of the bus fall off on truncation.
        be_o = NBYTES'(mask_s) << off_i;
    end

    // Load extraction: keep_s selects the payload, the rest is filled with the sign bit.
    // A full-width keep mask (WORD on 32-bit, DOUBLE) makes the unsigned flag irrelevant.
    always_comb begin
        shifted_s = rdata_i >> {off_i, 3'b000};
        keep_s    = {XLEN{1'b1}};
        sign_s    = 1'b0;
        case (width_i)
            LSU_WIDTH_BYTE: begin
                keep_s = XLEN'(8'hFF);
                sign_s = shifted_s[7];
            end
            LSU_WIDTH_HALF: begin
                keep_s = XLEN'(16'hFFFF);
                sign_s = shifted_s[15];
            end
            LSU_WIDTH_WORD: begin
                keep_s = XLEN'(32'hFFFF_FFFF);
                sign_s = shifted_s[31];
            end
            LSU_WIDTH_DOUBLE: begin
                keep_s = {XLEN{1'b1}};
                sign_s = 1'b0;
            end
            default: begin
                keep_s = {XLEN{1'b1}};
                sign_s = 1'b0;
            end
        endcase
        ext_s   = sign_s & ~unsigned_i;
        rdata_o = (shifted_s & keep_s) | ({XLEN{ext_s}} & ~keep_s);
    end

endmodule

// File: rtl/panda_lsu.sv
// panda_lsu: single-outstanding load-store unit between EX/MEM and the data bus.
//   clk_i, rst_i          - clock, asynchronous active-high reset
//   req_*                 - valid/ready request from the pipeline (store, width, unsigned, addr, wdata)
//   resp_*                - one-cycle completion pulse with extended load data and error flag
//   busy_o                - an access is in flight
//   bus                   - data-memory bus (master side)
module panda_lsu
    import panda_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_store_i,
    input  lsu_width_e        req_width_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_wdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   resp_rdata_o,
    output logic              resp_err_o,
    output logic              busy_o,
    panda_lsu_if.master       bus
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    lsu_state_e        state_r;
    logic              store_r;
    lsu_width_e        width_r;
    logic              unsigned_r;
    logic [OFF_W-1:0]  off_r;
    logic              ready_r;
    logic              busy_r;
    logic              data_req_r;
    logic              data_we_r;
    logic [NBYTES-1:0] data_be_r;
    logic [ADDR_W-1:0] data_addr_r;
    logic [XLEN-1:0]   data_wdata_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [XLEN-1:0]   resp_rdata_r;

    lsu_width_e        width_sel_s;
    logic              unsigned_sel_s;
    logic [OFF_W-1:0]  off_sel_s;
    logic              bad_s;
    logic [NBYTES-1:0] be_s;
    logic [XLEN-1:0]   wdata_rep_s;
    logic [XLEN-1:0]   rdata_fmt_s;

    // The aligner sees the live request while idle and the captured one afterwards.
    always_comb begin
        if (state_r == LSU_IDLE) begin
            width_sel_s    = req_width_i;
            unsigned_sel_s = req_unsigned_i;
            off_sel_s      = req_addr_i[OFF_W-1:0];
        end else begin
            width_sel_s    = width_r;
            unsigned_sel_s = unsigned_r;
            off_sel_s      = off_r;
        end
        bad_s = lsu_misaligned(req_width_i, req_addr_i[2:0]) ||
                ((XLEN == 32) && (req_width_i == LSU_WIDTH_DOUBLE));
    end

    panda_lsu_align #(.XLEN(XLEN)) u_align (
        .width_i    (width_sel_s),
        .unsigned_i (unsigned_sel_s),
        .off_i      (off_sel_s),
        .wdata_i    (req_wdata_i),
        .rdata_i    (bus.data_rdata_i),
        .be_o       (be_s),
        .wdata_o    (wdata_rep_s),
        .rdata_o    (rdata_fmt_s)
    );

    // Access FSM with request capture and registered bus/response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= LSU_IDLE;
            store_r      <= 1'b0;
            width_r      <= LSU_WIDTH_BYTE;
            unsigned_r   <= 1'b0;
            off_r        <= '0;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            data_req_r   <= 1'b0;
            data_we_r    <= 1'b0;
            data_be_r    <= '0;
            data_addr_r  <= '0;
            data_wdata_r <= '0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= '0;
        end else begin
            case (state_r)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        store_r      <= req_store_i;
                        width_r      <= req_width_i;
                        unsigned_r   <= req_unsigned_i;
                        off_r        <= req_addr_i[OFF_W-1:0];
                        data_we_r    <= req_store_i;
                        data_be_r    <= be_s;
                        data_addr_r  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        data_wdata_r <= wdata_rep_s;
                        ready_r      <= 1'b0;
                        busy_r       <= 1'b1;
                        if (bad_s) begin
                            // Rejected accesses answer immediately and never touch the bus.
                            state_r      <= LSU_ERR;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= '0;
                        end else begin
                            state_r    <= LSU_REQ;
                            data_req_r <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                LSU_REQ: begin
                    if (bus.data_gnt_i) begin
                        state_r    <= LSU_WAIT;
                        data_req_r <= 1'b0;
                    end else begin
                        data_req_r <= 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        state_r      <= LSU_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= bus.data_err_i;
                        // Stores and failed loads return zero data.
                        resp_rdata_r <= (store_r || bus.data_err_i) ? '0 : rdata_fmt_s;
                    end else begin
                        resp_valid_r <= 1'b0;
                    end
                end
                LSU_RESP, LSU_ERR: begin
                    state_r      <= LSU_IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                    ready_r      <= 1'b1;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r      <= LSU_IDLE;
                    data_req_r   <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= '0;
                    ready_r      <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o      = ready_r;
    assign busy_o           = busy_r;
    assign resp_valid_o     = resp_valid_r;
    assign resp_err_o       = resp_err_r;
    assign resp_rdata_o     = resp_rdata_r;
    assign bus.data_req_o   = data_req_r;
    assign bus.data_we_o    = data_we_r;
    assign bus.data_be_o    = data_be_r;
    assign bus.data_addr_o  = data_addr_r;
    assign bus.data_wdata_o = data_wdata_r;

endmodule
